// File: rtl/branch_predictor_1bit.sv
// 1-bit direct-mapped branch predictor with target buffer.
// Predicts combinationally at fetch, trains and flags mispredicts from EX.
module branch_predictor_1bit #(
  parameter int INDEX_BITS = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] IF_PC,
  output logic        PRED_TAKEN,
  output logic [31:0] PRED_TARGET,
  input  logic        EX_VALID,
  input  logic [31:0] EX_PC,
  input  logic        EX_PRED_TAKEN,
  input  logic [31:0] EX_PRED_TARGET,
  input  logic        EX_TAKEN,
  input  logic [31:0] EX_TARGET,
  output logic        MISS,
  output logic        FLUSH,
  output logic [31:0] CORRECT_PC
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 32 - INDEX_BITS - 2;

  logic [ENTRIES-1:0]             valid_q, valid_d;
  logic [ENTRIES-1:0]             hist_q, hist_d;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [ENTRIES-1:0][31:0]       target_q, target_d;
  logic                           miss_q, miss_d;
  logic [31:0]                    correct_pc_q, correct_pc_d;

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]      if_tag, ex_tag;
  logic                  if_hit, mispredict;

  assign if_idx = IF_PC[INDEX_BITS+1:2];
  assign if_tag = IF_PC[31:INDEX_BITS+2];
  assign ex_idx = EX_PC[INDEX_BITS+1:2];
  assign ex_tag = EX_PC[31:INDEX_BITS+2];

  // Prediction reads the registered table only, so a same-cycle update is not visible.
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    PRED_TAKEN  = if_hit && hist_q[if_idx];
    PRED_TARGET = PRED_TAKEN ? target_q[if_idx] : IF_PC + 32'd4;
  end

  always_comb begin
    mispredict = EX_VALID &&
                 ((EX_PRED_TAKEN != EX_TAKEN) ||
                  (EX_PRED_TAKEN && EX_TAKEN && (EX_PRED_TARGET != EX_TARGET)));
    miss_d       = mispredict;
    correct_pc_d = correct_pc_q;
    if (mispredict) correct_pc_d = EX_TAKEN ? EX_TARGET : EX_PC + 32'd4;
  end

  // Every resolved branch claims its slot; a tag mismatch simply replaces it.
  always_comb begin
    valid_d  = valid_q;
    hist_d   = hist_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (EX_VALID) begin
      valid_d[ex_idx] = 1'b1;
      hist_d[ex_idx]  = EX_TAKEN;
      tag_d[ex_idx]   = ex_tag;
      if (EX_TAKEN) target_d[ex_idx] = EX_TARGET;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      valid_q      <= '0;
      hist_q       <= '0;
      miss_q       <= 1'b0;
      correct_pc_q <= '0;
    end else begin
      valid_q      <= valid_d;
      hist_q       <= hist_d;
      miss_q       <= miss_d;
      correct_pc_q <= correct_pc_d;
    end
  end

  // Tag/target are don't-care while the valid bit is clear, so they carry no reset.
  always_ff @(posedge CLOCK) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign MISS       = miss_q;
  assign FLUSH      = miss_q;
  assign CORRECT_PC = correct_pc_q;
endmodule

// File: tb/tb_branch_predictor_1bit.sv
// Bench for branch_predictor_1bit: directed scenarios plus random traffic
// checked against a table-of-last-branch reference model.
module tb_branch_predictor_1bit;
  localparam int IB  = 4;
  localparam int ENT = 1 << IB;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] IF_PC;
  logic        PRED_TAKEN;
  logic [31:0] PRED_TARGET;
  logic        EX_VALID;
  logic [31:0] EX_PC;
  logic        EX_PRED_TAKEN;
  logic [31:0] EX_PRED_TARGET;
  logic        EX_TAKEN;
  logic [31:0] EX_TARGET;
  logic        MISS;
  logic        FLUSH;
  logic [31:0] CORRECT_PC;

  int total = 0;
  int bad   = 0;

  // Reference model: remembers the full PC, direction and last taken target per slot.
  bit          m_valid [ENT];
  bit          m_taken [ENT];
  logic [31:0] m_pc    [ENT];
  logic [31:0] m_tgt   [ENT];
  logic        exp_miss;
  logic [31:0] exp_cpc;

  branch_predictor_1bit #(.INDEX_BITS(IB)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .IF_PC(IF_PC),
    .PRED_TAKEN(PRED_TAKEN), .PRED_TARGET(PRED_TARGET),
    .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_PRED_TAKEN(EX_PRED_TAKEN),
    .EX_PRED_TARGET(EX_PRED_TARGET), .EX_TAKEN(EX_TAKEN), .EX_TARGET(EX_TARGET),
    .MISS(MISS), .FLUSH(FLUSH), .CORRECT_PC(CORRECT_PC)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0;
      m_taken[i] = 0;
    end
    exp_miss = 1'b0;
    exp_cpc  = 32'd0;
  endtask

  task automatic model_pred(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
    int s;
    s   = slot(pc);
    t   = m_valid[s] && ((m_pc[s] / (4 * ENT)) == (pc / (4 * ENT))) && m_taken[s];
    tgt = t ? m_tgt[s] : pc + 32'd4;
  endtask

  task automatic model_step();
    logic wrong;
    int   s;
    wrong = (EX_PRED_TAKEN != EX_TAKEN) ||
            (EX_PRED_TAKEN && EX_TAKEN && EX_PRED_TARGET != EX_TARGET);
    exp_miss = EX_VALID && wrong;
    if (exp_miss) exp_cpc = EX_TAKEN ? EX_TARGET : EX_PC + 32'd4;
    if (EX_VALID) begin
      s          = slot(EX_PC);
      m_valid[s] = 1;
      m_pc[s]    = EX_PC;
      m_taken[s] = EX_TAKEN;
      if (EX_TAKEN) m_tgt[s] = EX_TARGET;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic pt,
                       input logic [31:0] ptg, input logic t, input logic [31:0] tg);
    EX_VALID = v; EX_PC = pc; EX_PRED_TAKEN = pt;
    EX_PRED_TARGET = ptg; EX_TAKEN = t; EX_TARGET = tg;
  endtask

  // One cycle: drive at negedge, advance model at posedge, return 1 time unit later.
  task automatic do_ex(input logic v, input logic [31:0] pc, input logic pt,
                       input logic [31:0] ptg, input logic t, input logic [31:0] tg);
    @(negedge CLOCK);
    drive(v, pc, pt, ptg, t, tg);
    @(posedge CLOCK);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] pc;
    RESET = 1'b1;
    IF_PC = 32'h0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    total++; if (MISS !== 1'b0)   begin bad++; $display("FAIL reset_miss got=%b exp=0", MISS); end
    total++; if (FLUSH !== 1'b0)  begin bad++; $display("FAIL reset_flush got=%b exp=0", FLUSH); end
    total++; if (CORRECT_PC !== 32'h0) begin bad++; $display("FAIL reset_cpc got=%h exp=0", CORRECT_PC); end
    for (int i = 0; i < 4; i++) begin
      pc = (i == 3) ? 32'hFFFF_FFFC : $urandom;
      IF_PC = pc; #1;
      total++;
      if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== pc + 32'd4) begin
        bad++; $display("FAIL reset_pred pc=%h got=%b/%h exp=0/%h", pc, PRED_TAKEN, PRED_TARGET, pc + 32'd4);
      end
    end
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  task automatic test_cold_start();
    do_ex(1, 32'h100, 0, 32'h0, 1, 32'h200);
    total++;
    if (MISS !== 1'b1 || FLUSH !== 1'b1 || CORRECT_PC !== 32'h200) begin
      bad++; $display("FAIL cold_miss got=%b/%b/%h exp=1/1/00000200", MISS, FLUSH, CORRECT_PC);
    end
    do_ex(0, 0, 0, 0, 0, 0);
    IF_PC = 32'h100; #1;
    total++;
    if (PRED_TAKEN !== 1'b1 || PRED_TARGET !== 32'h200) begin
      bad++; $display("FAIL cold_pred got=%b/%h exp=1/00000200", PRED_TAKEN, PRED_TARGET);
    end
    total++;
    if (MISS !== 1'b0 || FLUSH !== 1'b0) begin
      bad++; $display("FAIL idle_miss got=%b/%b exp=0/0", MISS, FLUSH);
    end
  endtask

  task automatic test_correct();
    do_ex(1, 32'h100, 1, 32'h200, 1, 32'h200);
    total++;
    if (MISS !== 1'b0 || CORRECT_PC !== 32'h200) begin
      bad++; $display("FAIL correct_nomiss got=%b/%h exp=0/00000200", MISS, CORRECT_PC);
    end
    IF_PC = 32'h100; #1;
    total++;
    if (PRED_TAKEN !== 1'b1 || PRED_TARGET !== 32'h200) begin
      bad++; $display("FAIL correct_pred got=%b/%h exp=1/00000200", PRED_TAKEN, PRED_TARGET);
    end
    // Right direction but wrong target still mispredicts.
    do_ex(1, 32'h100, 1, 32'h300, 1, 32'h200);
    total++;
    if (MISS !== 1'b1 || CORRECT_PC !== 32'h200) begin
      bad++; $display("FAIL target_miss got=%b/%h exp=1/00000200", MISS, CORRECT_PC);
    end
  endtask

  task automatic test_not_taken_flip();
    do_ex(1, 32'h100, 1, 32'h200, 0, 32'h0);
    total++;
    if (MISS !== 1'b1 || FLUSH !== 1'b1 || CORRECT_PC !== 32'h104) begin
      bad++; $display("FAIL flip_miss got=%b/%b/%h exp=1/1/00000104", MISS, FLUSH, CORRECT_PC);
    end
    IF_PC = 32'h100; #1;
    total++;
    if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h104) begin
      bad++; $display("FAIL flip_pred got=%b/%h exp=0/00000104", PRED_TAKEN, PRED_TARGET);
    end
    // Taken again: the stored target survived the not-taken update.
    do_ex(1, 32'h100, 0, 32'h0, 1, 32'h200);
    do_ex(0, 0, 0, 0, 0, 0);
    IF_PC = 32'h100; #1;
    total++;
    if (PRED_TAKEN !== 1'b1 || PRED_TARGET !== 32'h200) begin
      bad++; $display("FAIL retrain_pred got=%b/%h exp=1/00000200", PRED_TAKEN, PRED_TARGET);
    end
  endtask

  task automatic test_alias();
    do_ex(1, 32'h140, 0, 32'h0, 0, 32'h0);
    total++;
    if (MISS !== 1'b0) begin bad++; $display("FAIL alias_nomiss got=%b exp=0", MISS); end
    IF_PC = 32'h100; #1;
    total++;
    if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h104) begin
      bad++; $display("FAIL alias_pred got=%b/%h exp=0/00000104", PRED_TAKEN, PRED_TARGET);
    end
  endtask

  task automatic test_same_cycle();
    do_ex(1, 32'h180, 0, 32'h0, 1, 32'h400);
    @(negedge CLOCK);
    drive(1, 32'h180, 1, 32'h400, 0, 32'h0);
    IF_PC = 32'h180; #1;
    total++;
    if (PRED_TAKEN !== 1'b1 || PRED_TARGET !== 32'h400) begin
      bad++; $display("FAIL bypass_pre got=%b/%h exp=1/00000400", PRED_TAKEN, PRED_TARGET);
    end
    @(posedge CLOCK);
    model_step();
    #1;
    total++;
    if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h184) begin
      bad++; $display("FAIL bypass_post got=%b/%h exp=0/00000184", PRED_TAKEN, PRED_TARGET);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    int         cnt;
    cnt = 0;
    do_ex(1, 32'h200, 0, 32'h0, 1, 32'h600); pat[3] = MISS; cnt += int'(MISS);
    do_ex(1, 32'h204, 1, 32'h700, 0, 32'h0); pat[2] = MISS; cnt += int'(MISS);
    do_ex(1, 32'hFFFF_FFFC, 1, 32'h10, 0, 32'h0); pat[1] = MISS; cnt += int'(MISS);
    total++;
    if (CORRECT_PC !== 32'h0) begin bad++; $display("FAIL wrap_cpc got=%h exp=00000000", CORRECT_PC); end
    do_ex(1, 32'h200, 1, 32'h600, 1, 32'h600); pat[0] = MISS; cnt += int'(MISS);
    total++;
    if (pat !== 4'b1110) begin bad++; $display("FAIL stream_pattern got=%b exp=1110", pat); end
    total++;
    if (cnt != 3) begin bad++; $display("FAIL stream_count got=%0d exp=3", cnt); end
  endtask

  task automatic test_random();
    logic [31:0] pc, ptg, tg, ipc, etgt;
    logic        pt, t, v, et;
    for (int n = 0; n < 400; n++) begin
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'h1000 + 4 * $urandom_range(0, 31);
      tg = 32'h2000 + 4 * $urandom_range(0, 3);
      t  = $urandom_range(0, 1);
      v  = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 1)) model_pred(pc, pt, ptg);
      else begin pt = $urandom_range(0, 1); ptg = 32'h2000 + 4 * $urandom_range(0, 3); end
      do_ex(v, pc, pt, ptg, t, tg);
      total++;
      if (MISS !== exp_miss || FLUSH !== exp_miss || CORRECT_PC !== exp_cpc) begin
        bad++; $display("FAIL rand_miss n=%0d got=%b/%b/%h exp=%b/%b/%h", n, MISS, FLUSH, CORRECT_PC, exp_miss, exp_miss, exp_cpc);
      end
      ipc = 32'h1000 + 4 * $urandom_range(0, 31);
      IF_PC = ipc; #1;
      model_pred(ipc, et, etgt);
      total++;
      if (PRED_TAKEN !== et || PRED_TARGET !== etgt) begin
        bad++; $display("FAIL rand_pred n=%0d pc=%h got=%b/%h exp=%b/%h", n, ipc, PRED_TAKEN, PRED_TARGET, et, etgt);
      end
    end
  endtask

  task automatic test_async_reset();
    do_ex(1, 32'h100, 0, 32'h0, 1, 32'h200);
    total++;
    if (MISS !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b exp=1", MISS); end
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    total++;
    if (MISS !== 1'b0 || FLUSH !== 1'b0 || CORRECT_PC !== 32'h0) begin
      bad++; $display("FAIL areset_now got=%b/%b/%h exp=0/0/00000000", MISS, FLUSH, CORRECT_PC);
    end
    IF_PC = 32'h100; #1;
    total++;
    if (PRED_TAKEN !== 1'b0 || PRED_TARGET !== 32'h104) begin
      bad++; $display("FAIL areset_pred got=%b/%h exp=0/00000104", PRED_TAKEN, PRED_TARGET);
    end
    // An update presented while reset is held must leave no trace.
    drive(1, 32'h100, 0, 32'h0, 1, 32'h200);
    @(posedge CLOCK); #1;
    total++;
    if (MISS !== 1'b0 || PRED_TAKEN !== 1'b0) begin
      bad++; $display("FAIL areset_inflight got=%b/%b exp=0/0", MISS, PRED_TAKEN);
    end
    @(negedge CLOCK);
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    do_ex(1, 32'h100, 0, 32'h0, 1, 32'h240);
    total++;
    if (MISS !== 1'b1 || CORRECT_PC !== 32'h240) begin
      bad++; $display("FAIL areset_first got=%b/%h exp=1/00000240", MISS, CORRECT_PC);
    end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_correct();
    test_not_taken_flip();
    test_alias();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor_1bit.md
BRANCH_PREDICTOR_1BIT -- requirements
Module: branch_predictor_1bit

Interface
REQ-001 Parameter: INDEX_BITS, default 4, log2 of table entries (16 entries).
REQ-002 Port: CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: RESET  input  1  reset; asynchronous, active-high.
REQ-004 Port: IF_PC  input  32  fetch-stage PC to predict.
REQ-005 Port: PRED_TAKEN  output  1  combinational prediction for IF_PC.
REQ-006 Port: PRED_TARGET  output  32  combinational predicted target for IF_PC.
REQ-007 Port: EX_VALID  input  1  a branch resolves in EX this cycle.
REQ-008 Port: EX_PC  input  32  PC of the resolving branch.
REQ-009 Port: EX_PRED_TAKEN  input  1  prediction carried down the pipe with that branch.
REQ-010 Port: EX_PRED_TARGET  input  32  predicted target carried down the pipe.
REQ-011 Port: EX_TAKEN  input  1  actual branch outcome.
REQ-012 Port: EX_TARGET  input  32  actual branch target.
REQ-013 Port: MISS  output  1  registered one-cycle pulse per misprediction; drives the miss counter's MISS input.
REQ-014 Port: FLUSH  output  1  registered; equals MISS; requests an IF/ID flush.
REQ-015 Port: CORRECT_PC  output  32  registered redirect PC, valid while FLUSH=1.

Function
REQ-016 Table: 2^INDEX_BITS entries, each holding VALID (1b), TAG (32-INDEX_BITS-2 b), HIST (1b), TARGET (32b).
REQ-017 Index = PC[INDEX_BITS+1:2]; tag = PC[31:INDEX_BITS+2]; PC[1:0] is ignored.
REQ-018 Hit = VALID and TAG match for IF_PC; PRED_TAKEN = hit AND HIST; PRED_TARGET = TARGET when PRED_TAKEN, else IF_PC+4 (mod 2^32).
REQ-019 Mispredict = EX_VALID AND ((EX_PRED_TAKEN != EX_TAKEN) OR (EX_PRED_TAKEN AND EX_TAKEN AND EX_PRED_TARGET != EX_TARGET)).
REQ-020 MISS and FLUSH are high exactly in the cycle after a mispredicting EX_VALID cycle (latency 1); otherwise 0.
REQ-021 Back-to-back mispredicts keep MISS high on consecutive cycles, one cycle per mispredict.
REQ-022 CORRECT_PC is loaded on a mispredict: EX_TARGET if EX_TAKEN, else EX_PC+4 (wraps at 2^32). It holds its value otherwise.
REQ-023 Update on every EX_VALID cycle:
  - HIST[idx] <= EX_TAKEN; TAG[idx] <= EX_PC tag; VALID[idx] <= 1.
  - When EX_TAKEN = 1: TARGET[idx] <= EX_TARGET.
  - When EX_TAKEN = 0: TARGET is unchanged.
REQ-024 A tag mismatch on update overwrites (replaces) the entry; there is no other replacement policy.
REQ-025 Same-index read and update in the same cycle: the prediction uses the pre-update entry (no bypass).
REQ-026 EX_VALID=0: no table write; MISS=0 next cycle.

Reset
REQ-027 RESET=1 asynchronously clears all VALID and HIST bits, sets MISS=0, FLUSH=0 and CORRECT_PC=0, regardless of CLOCK.
REQ-028 TAG and TARGET need not be reset; they are unobservable while VALID=0.
REQ-029 After reset, PRED_TAKEN=0 and PRED_TARGET=IF_PC+4 for every PC.
REQ-030 RESET asserted mid-pulse drops MISS/FLUSH immediately; an update in flight on that edge is discarded.
REQ-031 The first rising edge after RESET deasserts behaves as a normal cycle.

Verification
REQ-032 Cold start, reset then EX_VALID=1, EX_PC=0x100, EX_PRED_TAKEN=0, EX_TAKEN=1, EX_TARGET=0x200 -> next cycle MISS=1, FLUSH=1, CORRECT_PC=0x200; thereafter IF_PC=0x100 gives PRED_TAKEN=1, PRED_TARGET=0x200.
REQ-033 Correct prediction, EX_PC=0x100, EX_PRED_TAKEN=1, EX_PRED_TARGET=0x200, EX_TAKEN=1, EX_TARGET=0x200 -> MISS stays 0; entry unchanged.
REQ-034 Not-taken flip, same branch resolves EX_TAKEN=0 with EX_PRED_TAKEN=1 -> MISS=1, CORRECT_PC=0x104; IF_PC=0x100 then gives PRED_TAKEN=0.
REQ-035 Alias, train 0x100 taken, then resolve 0x140 not taken (same index, INDEX_BITS=4) -> IF_PC=0x100 predicts not taken (tag miss).
REQ-036 Miss stream, drive EX_VALID mispredicts on 3 consecutive cycles, then 1 correct -> MISS pattern 1,1,1,0; a connected miss counter advances by 3.
REQ-037 Async reset, assert RESET between clock edges while MISS=1 -> MISS, FLUSH and CORRECT_PC go to 0 at once; IF_PC=0x100 predicts not taken.
